// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and sizes for the 8x8 row-scan display
package disp_pkg;
  localparam int DISP_ROWS = 8;
  localparam int DISP_COLS = 8;

  typedef logic [2:0] row_t;
  typedef logic [DISP_COLS-1:0] col_t;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;
endpackage

// File: rtl/disp_frame_buf.sv
// rtl/disp_frame_buf.sv - double-buffered 8x8 frame store, write to back bank, read front bank
module disp_frame_buf
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en_i,
  input  logic [2:0] wr_row_i,
  input  logic [7:0] wr_data_i,
  input  logic       toggle_i,
  input  logic [2:0] rd_row_i,
  output logic [7:0] rd_data_o
);

  col_t bank_q [2][DISP_ROWS];
  logic front_q;

  // Write targets the pre-toggle back bank, so a write on the swap edge lands in the new front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < DISP_ROWS; r++) begin
          bank_q[b][r] <= '0;
        end
      end
    end else begin
      if (wr_en_i) begin
        bank_q[~front_q][wr_row_i] <= wr_data_i;
      end
      if (toggle_i) begin
        front_q <= ~front_q;
      end
    end
  end

  assign rd_data_o = bank_q[front_q][rd_row_i];

endmodule

// File: rtl/disp_row_scan.sv
// rtl/disp_row_scan.sv - row-scan controller: row timing FSM, blanking, frame-boundary buffer swap
module disp_row_scan
  import disp_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic [2:0] row_sel,
  output logic       row_blank,
  output logic [7:0] col_data,
  output logic       frame_start
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] ROW_LAST   = CW'(PRESCALE - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d;
  logic [7:0]    col_q, col_d;
  logic          ack_q, ack_d;
  logic          fs_q, fs_d;
  logic          row_end;
  logic          wrap;
  logic [7:0]    front_row;

  disp_frame_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (wr_en),
    .wr_row_i (wr_row),
    .wr_data_i(wr_data),
    .toggle_i (ack_d),
    .rd_row_i (row_q),
    .rd_data_o(front_row)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    row_d   = row_q;
    row_end = 1'b0;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW: begin
        if (cnt_q == ROW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          row_d   = row_q + 3'd1;
          row_end = 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
    wrap  = row_end && (row_q == 3'd7);
    fs_d  = wrap;
    ack_d = wrap && swap_req;
    // Swap only happens on entry to BLANK, so the current front row is valid whenever SHOW is next.
    col_d = (state_d == ST_SHOW) ? front_row : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      row_q   <= 3'd0;
      col_q   <= 8'h00;
      ack_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ack_q   <= ack_d;
      fs_q    <= fs_d;
    end
  end

  assign row_sel     = row_q;
  assign row_blank   = (state_q == ST_BLANK);
  assign col_data    = col_q;
  assign swap_ack    = ack_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_disp_row_scan.sv
// tb/tb_disp_row_scan.sv - directed self-checking bench for disp_row_scan (PRESCALE=8, BLANK=2)
module tb_disp_row_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic [2:0] row_sel;
  logic       row_blank;
  logic [7:0] col_data;
  logic       frame_start;

  int n_pass = 0;
  int n_total = 0;

  int t;
  logic [7:0] mb [2][8];
  logic mfront;
  logic auto_drop;
  int obs_acks;
  int last_ack_t;
  int ack_gap;

  always #5 clk = ~clk;

  disp_row_scan #(.PRESCALE(8), .BLANK(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .row_sel    (row_sel),
    .row_blank  (row_blank),
    .col_data   (col_data),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h expected=%0h", tag, t, got, exp);
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 8; r++) mb[b][r] = 8'h00;
    mfront = 1'b0;
    t = 0;
  endtask

  // One clock: update the time-indexed model from the held inputs, then compare all outputs.
  task automatic step();
    logic wrap, exp_ack;
    logic [2:0] row;
    logic blank;
    wrap = ((t + 1) % 64) == 0;
    if (wr_en) mb[~mfront][wr_row] = wr_data;
    exp_ack = wrap && swap_req;
    if (exp_ack) mfront = ~mfront;
    @(posedge clk);
    #2;
    t++;
    row   = 3'((t / 8) % 8);
    blank = (t % 8) < 2;
    chk("row_sel", 32'(row_sel), 32'(row));
    chk("row_blank", 32'(row_blank), 32'(blank));
    chk("col_data", 32'(col_data), blank ? 32'h0 : 32'(mb[mfront][row]));
    chk("frame_start", 32'(frame_start), 32'(wrap));
    chk("swap_ack", 32'(swap_ack), 32'(exp_ack));
    if (swap_ack) begin
      obs_acks++;
      ack_gap = t - last_ack_t;
      last_ack_t = t;
    end
    if (auto_drop && exp_ack) swap_req = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    wr_en = 1'b1;
    wr_row = r;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int a0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_row = 3'd0;
    wr_data = 8'h00;
    swap_req = 1'b0;
    auto_drop = 1'b1;
    obs_acks = 0;
    last_ack_t = 0;
    ack_gap = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_row_sel", 32'(row_sel), 32'h0);
    chk("rst_row_blank", 32'(row_blank), 32'h1);
    chk("rst_col_data", 32'(col_data), 32'h0);
    chk("rst_swap_ack", 32'(swap_ack), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);

    // Free-run over a full frame plus a wrap.
    rst_n = 1'b1;
    run(70);

    // Write row 3 then request swap mid-frame.
    write_row(3'd3, 8'hA5);
    swap_req = 1'b1;
    a0 = obs_acks;
    while ((t % 64) != 0) step();
    chk("swap1_ack_count", 32'(obs_acks - a0), 32'd1);
    chk("swap1_ack_at_wrap", 32'(last_ack_t % 64), 32'd0);
    run(64);

    // Write without swap for a full frame: display unchanged.
    write_row(3'd1, 8'h0F);
    a0 = obs_acks;
    run(64);
    chk("noswap_ack_count", 32'(obs_acks - a0), 32'd0);

    // Write on the swap edge itself.
    swap_req = 1'b1;
    a0 = obs_acks;
    while (((t + 1) % 64) != 0) step();
    write_row(3'd5, 8'h3C);
    chk("edge_write_ack", 32'(obs_acks - a0), 32'd1);
    run(64);

    // Reset mid-row 4 with a pending swap.
    while ((t % 64) != 35) step();
    swap_req = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_row_sel", 32'(row_sel), 32'h0);
    chk("midrst_row_blank", 32'(row_blank), 32'h1);
    chk("midrst_col_data", 32'(col_data), 32'h0);
    chk("midrst_swap_ack", 32'(swap_ack), 32'h0);
    chk("midrst_frame_start", 32'(frame_start), 32'h0);
    swap_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_clear();
    a0 = obs_acks;
    run(70);
    chk("postrst_ack_count", 32'(obs_acks - a0), 32'd0);

    // swap_req held across two frame boundaries.
    write_row(3'd0, 8'h81);
    swap_req = 1'b1;
    auto_drop = 1'b0;
    a0 = obs_acks;
    for (int i = 0; i < 200 && (obs_acks - a0) < 2; i++) step();
    swap_req = 1'b0;
    chk("hold_ack_count", 32'(obs_acks - a0), 32'd2);
    chk("hold_ack_gap", 32'(ack_gap), 32'd64);
    run(64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/disp_row_scan.md
# disp_row_scan

Row-scan controller for the 8x8 arrow/LED display. It holds a double-buffered 8x8 frame and cycles a 3-bit row index through rows 0-7 at a programmable rate. The row index drives the 3-to-8 active-low row decoder directly downstream. For each row it presents the matching column pattern, with a blanking interval at every row change to suppress ghosting. Game logic writes the back buffer and requests a swap, which is applied only at a frame boundary.

## Interface
Parameters:
- PRESCALE, default 1000: clock cycles per row; legal range 2..65535.
- BLANK, default 4: blanked cycles at the start of each row; legal range 1..PRESCALE-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- wr_en  input  1  write strobe to the back buffer.
- wr_row  input  3  back-buffer row address.
- wr_data  input  8  column pattern for wr_row; bit c is column c, 1 = lit.
- swap_req  input  1  level request to swap front and back buffers; held until swap_ack.
- swap_ack  output  1  one-cycle pulse; the swap took effect this cycle.
- row_sel  output  3  current row index, fed to the row decoder.
- row_blank  output  1  1 = blanking interval active.
- col_data  output  8  column drive for row_sel; forced to 0 while row_blank=1.
- frame_start  output  1  one-cycle pulse on every 7->0 row wrap.

## Operation
- Storage: two 8x8 buffers. Pointer front selects the displayed buffer; the other buffer is the back buffer.
- FSM states: BLANK and SHOW.
  - BLANK -> SHOW when the in-row counter reaches BLANK-1.
  - SHOW -> BLANK when the in-row counter reaches PRESCALE-1. On the same transition, row_sel increments, wrapping from 7 to 0.
- In-row counter: width $clog2(PRESCALE). Clears on every row change; no other wrap.
- col_data: 0 in BLANK; front[row_sel] in SHOW. Registered output.
- Writes: when wr_en=1, the back buffer row wr_row is written at the clock edge. The front buffer is never writable.
- Swap:
  - Occurs on the row 7->0 edge if swap_req=1 on that edge. front toggles.
  - swap_ack=1 for the first cycle of the new row 0, the same cycle as frame_start.
  - If swap_req is still high in the cycle after swap_ack, it counts as a new request and is served at the next frame boundary.
  - If swap_req is low at the wrap, nothing swaps and swap_ack stays 0.
- Write coincident with the swap edge: the data lands in the pre-swap back buffer, so it is visible in the new frame.
- Reset, whether at idle or mid-row/mid-frame:
  - Both buffers cleared to 0; front=0.
  - FSM=BLANK, counter=0, row_sel=0.
  - A pending swap is discarded.

## Timing
- Reset values: row_sel=0, row_blank=1, col_data=0, swap_ack=0, frame_start=0.
- Row period: exactly PRESCALE cycles. Frame period: 8*PRESCALE cycles.
- Within row r:
  - Cycles 0..BLANK-1: row_blank=1, col_data=0.
  - Cycles BLANK..PRESCALE-1: row_blank=0, col_data=front[r].
- All outputs are registered and change only on clk edges. row_sel, row_blank and col_data change on the same edge.
- The first row after reset release is row 0 in BLANK. frame_start does not pulse for this entry, only on 7->0 wraps.
- Write-to-display latency: from the swap edge. The written data appears BLANK cycles into row 0 of the new frame.

## Structure
- Shared package disp_pkg:
  - DISP_ROWS=8, DISP_COLS=8.
  - Row index type (3 bits) and column pattern type (8 bits).
  - FSM state enum {ST_BLANK, ST_SHOW}.
- Sub-module disp_frame_buf: two 8x8 register banks, with one write port (back bank) and one combinational read port (front bank), plus the front pointer toggle input.
- The top level holds the FSM, the counter, the swap arbitration and the output registers.

## Test plan
All scenarios use PRESCALE=8, BLANK=2.
- Reset then free-run:
  - row_sel steps 0,1,...,7,0 every 8 cycles.
  - row_blank=1 for the first 2 cycles of each row.
  - col_data=0 throughout, since buffers are cleared.
  - frame_start pulses once every 64 cycles.
- Write row 3 = 0xA5, assert swap_req mid-frame:
  - No change in col_data until the wrap.
  - swap_ack and frame_start pulse together on the 7->0 wrap.
  - In the next frame, col_data=0xA5 during cycles 2..7 of row 3.
- Hold swap_req low for a full frame after writes: no swap_ack; the display is unchanged.
- Write coinciding with the swap edge (row 5 = 0x3C): 0x3C is shown on row 5 in the new frame.
- Assert rst_n low mid-row 4 with a swap pending:
  - Outputs return immediately to reset values.
  - No swap_ack occurs afterwards.
  - A full frame then shows all zeros.
- swap_req held high for two frames: two swap_ack pulses 64 cycles apart; front toggles twice.
